seq_divider_8x4: RTL and testbench



---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 25 ++
 rtl/seq_divider_8x4.sv | 123 ++++++++++++
 tb/tb_seq_divider_8x4.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the 8/4 sequential restoring divider.
// The FSM walks IDLE -> CALC (one quotient bit per clock) -> DONE.
package div_pkg;

  localparam int N_W   = 8;
  localparam int D_W   = 4;
  localparam int CNT_W = $clog2(N_W);

  localparam logic [N_W-1:0] DZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference when it does not go negative.
module div_step
  import div_pkg::*;
(
  input  logic [D_W-1:0] rem_i,
  input  logic           dvd_bit_i,
  input  logic [D_W-1:0] divisor_i,
  output logic [D_W-1:0] new_rem_o,
  output logic           q_bit_o
);

  logic [D_W:0]   trial;
  logic [D_W-1:0] diff;

  // rem_i < divisor_i holds on entry, so a successful difference is always
  // below the divisor and the low D_W bits of the subtraction are exact.
  always_comb begin
    trial     = {rem_i, dvd_bit_i};
    diff      = trial[D_W-1:0] - divisor_i;
    q_bit_o   = (trial >= {1'b0, divisor_i});
    new_rem_o = q_bit_o ? diff : trial[D_W-1:0];
  end

endmodule

// File: rtl/seq_divider_8x4.sv
// Sequential restoring divider, 8-bit dividend / 4-bit divisor, one quotient
// bit per clock behind valid/ready handshakes on both sides.
//
//   state | meaning
//   IDLE  | in_ready high, waiting to accept an operand pair
//   CALC  | one restoring step per clock, quotient bit cnt_q resolved each edge
//   DONE  | out_valid high, result held until out_ready
module seq_divider_8x4 #(
  parameter int N_W = 8,
  parameter int D_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero
);

  import div_pkg::*;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q,   cnt_d;
  logic [N_W-1:0]         dvd_q,   dvd_d;
  logic [D_W-1:0]         dsr_q,   dsr_d;
  logic [D_W-1:0]         rem_q,   rem_d;
  logic [N_W-1:0]         quo_q,   quo_d;
  logic                   dz_q,    dz_d;

  logic [D_W-1:0]         step_rem;
  logic                   step_q_bit;

  div_step u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (dvd_q[cnt_q]),
    .divisor_i (dsr_q),
    .new_rem_o (step_rem),
    .q_bit_o   (step_q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = dividend;
          dsr_d = divisor;
          rem_d = '0;
          if (divisor == '0) begin
            quo_d   = DZ_QUOTIENT;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            quo_d   = '0;
            dz_d    = 1'b0;
            cnt_d   = CNT_W'(N_W - 1);
            state_d = CALC;
          end
        end
      end

      CALC: begin
        quo_d[cnt_q] = step_q_bit;
        rem_d        = step_rem;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_seq_divider_8x4.sv
// Directed bench for seq_divider_8x4: hand-computed vectors, backpressure,
// operand changes while busy, full nonzero-divisor sweep and mid-CALC reset.
module tb_seq_divider_8x4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int tests;
  int fails;
  int lat;

  seq_divider_8x4 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for a single edge, then count edges until out_valid.
  task automatic start(input logic [7:0] a, input logic [3:0] b, output int k);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_in_ready",  in_ready,    1);
    check("rst_out_valid", out_valid,   0);
    check("rst_quotient",  quotient,    0);
    check("rst_remainder", remainder,   0);
    check("rst_dz",        div_by_zero, 0);
    rst_n = 1'b1;
    tick();

    // 200 / 7 = 28 r 4
    start(8'd200, 4'd7, lat);
    check("200_7_latency", lat,         8);
    check("200_7_q",       quotient,    28);
    check("200_7_r",       remainder,   4);
    check("200_7_dz",      div_by_zero, 0);
    check("200_7_in_rdy",  in_ready,    0);
    tick();
    check("200_7_release_rdy",   in_ready,  1);
    check("200_7_release_valid", out_valid, 0);

    // 255 / 1 and 5 / 15
    start(8'd255, 4'd1, lat);
    check("255_1_q", quotient,  255);
    check("255_1_r", remainder, 0);
    tick();
    start(8'd5, 4'd15, lat);
    check("5_15_q", quotient,  0);
    check("5_15_r", remainder, 5);
    tick();

    // Divide by zero, then a normal op clears the flag
    start(8'd77, 4'd0, lat);
    check("dz_latency", lat,         0);
    check("dz_q",       quotient,    8'hFF);
    check("dz_r",       remainder,   0);
    check("dz_flag",    div_by_zero, 1);
    tick();
    check("dz_release_rdy", in_ready, 1);
    start(8'd9, 4'd3, lat);
    check("9_3_latency", lat,         8);
    check("9_3_q",       quotient,    3);
    check("9_3_r",       remainder,   0);
    check("9_3_dz",      div_by_zero, 0);
    tick();

    // Backpressure: 100 / 9 held for 5 cycles
    out_ready = 1'b0;
    start(8'd100, 4'd9, lat);
    check("bp_latency", lat, 8);
    for (int i = 0; i < 5; i++) begin
      dividend = 8'(i * 37 + 3);
      divisor  = 4'(i + 2);
      tick();
      check("bp_valid_hold", out_valid, 1);
      check("bp_q_hold",     quotient,  11);
      check("bp_r_hold",     remainder, 1);
      check("bp_in_ready",   in_ready,  0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_rdy",   in_ready,  1);
    check("bp_release_valid", out_valid, 0);

    // Operands keep changing with in_valid high while busy
    dividend = 8'd200;
    divisor  = 4'd7;
    in_valid = 1'b1;
    tick();
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("busy_in_ready", in_ready, 0);
      dividend = 8'($urandom_range(0, 255));
      divisor  = 4'($urandom_range(1, 15));
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("busy_latency", lat,       8);
    check("busy_q",       quotient,  28);
    check("busy_r",       remainder, 4);
    tick();

    // Full sweep of nonzero divisors
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        start(8'(a), 4'(b), lat);
        check("sweep_q", quotient,  32'(a / b));
        check("sweep_r", remainder, 32'(a % b));
        tick();
      end
    end

    // Reset during the 4th CALC cycle aborts the operation
    dividend = 8'd200;
    divisor  = 4'd7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid",  out_valid, 0);
    check("abort_in_rdy", in_ready,  1);
    check("abort_q",      quotient,  0);
    check("abort_r",      remainder, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("abort_idle_valid", out_valid, 0);
    start(8'd50, 4'd6, lat);
    check("50_6_latency", lat,       8);
    check("50_6_q",       quotient,  8);
    check("50_6_r",       remainder, 2);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
